vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator: horizontal and vertical counters, Hsync/Vsync,
//  data-enable and pixel X/Y coordinates for any mode, with run-time porch/sync/active sizes.
//  Sits between the pixel-clock domain and the pixel pipeline/DAC.
//  Generalises the single-axis sync counter to a full 4-region line/frame timing.
// PARAMETERS
//  H_WIDTH  11  bit width of every horizontal config field, H counter and X
//  V_WIDTH  10  bit width of every vertical config field, V counter and Y
// PORTS
//  Clk        in   1        system clock
//  Rst        in   1        synchronous reset, active-high
//  Pix_en     in   1        pixel-clock enable; all state advances only when 1
//  H_active   in   H_WIDTH  visible pixels per line (>=1)
//  H_fp       in   H_WIDTH  horizontal front porch, pixels
//  H_sync     in   H_WIDTH  horizontal sync pulse, pixels (>=1)
//  H_bp       in   H_WIDTH  horizontal back porch, pixels
//  V_active   in   V_WIDTH  visible lines per frame (>=1)
//  V_fp, V_sync, V_bp  in  V_WIDTH each  vertical porch/sync sizes, lines (V_sync>=1)
//  H_pol      in   1        Hsync active level (0 = active-low)
//  V_pol      in   1        Vsync active level
//  Hsync      out  1        registered horizontal sync
//  Vsync      out  1        registered vertical sync
//  De         out  1        registered data enable (visible pixel)
//  X          out  H_WIDTH  registered H counter value
//  Y          out  V_WIDTH  registered V counter value
//  Frame_start out 1        1-cycle pulse when X==0 && Y==0 is entered
//  Line_end   out  1        1-cycle pulse when X==H_total-1 is entered
//  Cfg_err    out  1        config invalid; counters held
// BEHAVIOUR
//  - H_total = H_active+H_fp+H_sync+H_bp, V_total likewise; sums in H_WIDTH+2 / V_WIDTH+2 bits.
//  - Line order: active [0,H_active), front porch, sync [H_active+H_fp, +H_sync), back porch.
//    Vertical identical in lines.
//  - Rst: X=0, Y=0, De=0, Hsync=0, Vsync=0, Frame_start=0, Line_end=0, Cfg_err=0.
//  - On each Clk with Pix_en=1: X advances; X==H_total-1 -> X=0 and Y advances;
//    Y==V_total-1 at line wrap -> Y=0.
//  - With Pix_en=0 all outputs hold; pulses drop to 0.
//  - All outputs are registered and describe the same (X,Y) in the same cycle.
//  - Flags are computed from the next counter value: zero extra latency between X/Y and flags.
//  - Hsync = H_pol when X is in the H sync region, else ~H_pol; Vsync uses V_pol in the V sync
//    region, line-granular.
//  - De = (X < H_active) && (Y < V_active).
//  - Frame_start/Line_end are high only for the enabled cycle that enters that position.
//  - Cfg_err=1 if H_active==0, H_sync==0, V_active==0, V_sync==0,
//    H_total > 2^H_WIDTH or V_total > 2^V_WIDTH.
//    While set: X=Y=0, De=0, syncs inactive, no pulses.
//    On clear: restart at (0,0) with Frame_start.
//  - Counter compare uses >= on the total, never ==, so a shrunk config cannot overshoot.
//  - Rst mid-frame: returns to (0,0) next cycle; the first enabled cycle after Rst pulses Frame_start.
// CONFIGURATION
//  VGA_TIMING_SHADOW_EN defined:
//   - all config/polarity inputs are captured into shadow registers on Rst and on every frame wrap
//     (entering (0,0)); the Cfg_err check also runs on the shadow copy.
//   - mid-frame config changes take effect only at the next frame.
//  Undefined:
//   - config inputs are used live every cycle; a change mid-frame alters timing immediately.
//   - >= compare guarantees wrap.
// TESTING
//  1) 640x480: H 640/16/96/48, V 480/10/2/33, pol 0/0, Pix_en=1 -> line 800 clk, frame 420000 clk;
//     Hsync low X 656..751; Vsync low Y 490..491.
//  2) Same mode, check De: De=1 exactly for X<640,Y<480 -> 307200 De cycles per frame;
//     Frame_start period 420000; Line_end period 800.
//  3) Pix_en toggled 1,0 alternating -> every output holds on 0 cycles;
//     line length doubles to 1600 clk; no pulse on hold cycles.
//  4) Set H_sync=0 mid-run -> Cfg_err=1 next cycle, X=Y=0, De=0, Hsync=~H_pol;
//     restore -> Frame_start on first enabled cycle.
//  5) Change H_active 640->320 at Y=100:
//     - SHADOW_EN: frame unchanged until the next Frame_start.
//     - else: next lines 480 clk, X never >=480.
//  6) Assert Rst at X=300,Y=200 for 1 cycle -> next cycle X=0,Y=0, all outputs at reset value;
//     the following enabled cycle gives Frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: run-time timing configuration plus registered raster outputs.
// Latency: n/a (wires only). Backpressure: none; Pix_en is the only pacing signal.
// Ports: master drives Pix_en, H/V sizes and polarities and observes the raster.
//        slave (the generator) consumes the config and drives Hsync, Vsync, De, X, Y,
//        Frame_start, Line_end and Cfg_err.
interface vga_timing_gen_if #(
  parameter int H_WIDTH = 11,
  parameter int V_WIDTH = 10
);
  // pixel-clock enable and configuration
  logic               Pix_en;
  logic [H_WIDTH-1:0] H_active;
  logic [H_WIDTH-1:0] H_fp;
  logic [H_WIDTH-1:0] H_sync;
  logic [H_WIDTH-1:0] H_bp;
  logic [V_WIDTH-1:0] V_active;
  logic [V_WIDTH-1:0] V_fp;
  logic [V_WIDTH-1:0] V_sync;
  logic [V_WIDTH-1:0] V_bp;
  logic               H_pol;
  logic               V_pol;

  // registered raster outputs
  logic               Hsync;
  logic               Vsync;
  logic               De;
  logic [H_WIDTH-1:0] X;
  logic [V_WIDTH-1:0] Y;
  logic               Frame_start;
  logic               Line_end;
  logic               Cfg_err;

  modport master (
    output Pix_en, H_active, H_fp, H_sync, H_bp,
           V_active, V_fp, V_sync, V_bp, H_pol, V_pol,
    input  Hsync, Vsync, De, X, Y, Frame_start, Line_end, Cfg_err
  );

  modport slave (
    input  Pix_en, H_active, H_fp, H_sync, H_bp,
           V_active, V_fp, V_sync, V_bp, H_pol, V_pol,
    output Hsync, Vsync, De, X, Y, Frame_start, Line_end, Cfg_err
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (H/V counters, syncs, data enable, X/Y, frame/line pulses).
// Latency: every output is registered; flags are derived from the next counter value, so X/Y
//          and all flags describe the same pixel in the same cycle. Backpressure: Pix_en=0 freezes
//          all state (pulses drop to 0); there is no ready path back to the source.
// Ports: Clk, Rst (synchronous, active-high), bus (vga_timing_gen_if.slave: Pix_en, H_active,
//        H_fp, H_sync, H_bp, V_active, V_fp, V_sync, V_bp, H_pol, V_pol in; Hsync, Vsync, De,
//        X, Y, Frame_start, Line_end, Cfg_err out).
// Optional feature: define VGA_TIMING_SHADOW_EN to latch the configuration into shadow registers
//        on Rst and on every entry to (0,0); otherwise the live configuration is used every cycle.
module vga_timing_gen #(
  parameter int H_WIDTH = 11,
  parameter int V_WIDTH = 10
) (
  input  logic            Clk,
  input  logic            Rst,
  vga_timing_gen_if.slave bus
);

  // Sums are two bits wider so four maximal fields cannot wrap.
  localparam int HW2 = H_WIDTH + 2;
  localparam int VW2 = V_WIDTH + 2;
  // Largest legal total: a counter of H_WIDTH bits must still hold H_total-1.
  localparam logic [HW2-1:0] H_LIMIT = {2'b01, {H_WIDTH{1'b0}}};
  localparam logic [VW2-1:0] V_LIMIT = {2'b01, {V_WIDTH{1'b0}}};

  // ST_START: next enabled cycle enters (0,0) with Frame_start (after Rst or a config error).
  // ST_RUN:   normal counting.
  // ST_HALT:  configuration invalid; counters parked at (0,0).
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // configuration actually used by the counters
  logic [H_WIDTH-1:0] c_h_active;
  logic [H_WIDTH-1:0] c_h_fp;
  logic [H_WIDTH-1:0] c_h_sync;
  logic [H_WIDTH-1:0] c_h_bp;
  logic [V_WIDTH-1:0] c_v_active;
  logic [V_WIDTH-1:0] c_v_fp;
  logic [V_WIDTH-1:0] c_v_sync;
  logic [V_WIDTH-1:0] c_v_bp;
  logic               c_h_pol;
  logic               c_v_pol;

  // region boundaries
  logic [HW2-1:0] h_sync_start;
  logic [HW2-1:0] h_sync_end;
  logic [HW2-1:0] h_total;
  logic [VW2-1:0] v_sync_start;
  logic [VW2-1:0] v_sync_end;
  logic [VW2-1:0] v_total;
  logic           cfg_bad;

  // counter state and next-position logic
  logic [H_WIDTH-1:0] x_q;
  logic [V_WIDTH-1:0] y_q;
  logic [HW2-1:0]     x_inc;
  logic [VW2-1:0]     y_inc;
  logic               h_wrap;
  logic               v_wrap;
  logic [HW2-1:0]     nx;
  logic [VW2-1:0]     ny;
  logic               enter_origin;

  // flags for the next position
  logic n_de;
  logic n_hsync;
  logic n_vsync;
  logic n_le;

  // registered outputs
  logic de_q;
  logic hsync_q;
  logic vsync_q;
  logic fs_q;
  logic le_q;
  logic err_q;

`ifdef VGA_TIMING_SHADOW_EN
  logic [H_WIDTH-1:0] sh_h_active;
  logic [H_WIDTH-1:0] sh_h_fp;
  logic [H_WIDTH-1:0] sh_h_sync;
  logic [H_WIDTH-1:0] sh_h_bp;
  logic [V_WIDTH-1:0] sh_v_active;
  logic [V_WIDTH-1:0] sh_v_fp;
  logic [V_WIDTH-1:0] sh_v_sync;
  logic [V_WIDTH-1:0] sh_v_bp;
  logic               sh_h_pol;
  logic               sh_v_pol;

  // Reload on Rst, on every frame entry, and on every enabled cycle while the held copy is
  // invalid -- otherwise a bad shadow copy could never be replaced and the block would stay
  // halted forever. Flags for the (0,0) entry cycle still come from the outgoing copy.
  always_ff @(posedge Clk) begin
    if (Rst || (bus.Pix_en && (cfg_bad || enter_origin))) begin
      sh_h_active <= bus.H_active;
      sh_h_fp     <= bus.H_fp;
      sh_h_sync   <= bus.H_sync;
      sh_h_bp     <= bus.H_bp;
      sh_v_active <= bus.V_active;
      sh_v_fp     <= bus.V_fp;
      sh_v_sync   <= bus.V_sync;
      sh_v_bp     <= bus.V_bp;
      sh_h_pol    <= bus.H_pol;
      sh_v_pol    <= bus.V_pol;
    end
  end

  assign c_h_active = sh_h_active;
  assign c_h_fp     = sh_h_fp;
  assign c_h_sync   = sh_h_sync;
  assign c_h_bp     = sh_h_bp;
  assign c_v_active = sh_v_active;
  assign c_v_fp     = sh_v_fp;
  assign c_v_sync   = sh_v_sync;
  assign c_v_bp     = sh_v_bp;
  assign c_h_pol    = sh_h_pol;
  assign c_v_pol    = sh_v_pol;
`else
  assign c_h_active = bus.H_active;
  assign c_h_fp     = bus.H_fp;
  assign c_h_sync   = bus.H_sync;
  assign c_h_bp     = bus.H_bp;
  assign c_v_active = bus.V_active;
  assign c_v_fp     = bus.V_fp;
  assign c_v_sync   = bus.V_sync;
  assign c_v_bp     = bus.V_bp;
  assign c_h_pol    = bus.H_pol;
  assign c_v_pol    = bus.V_pol;
`endif

  // Line layout: active, front porch, sync, back porch.
  assign h_sync_start = {2'b00, c_h_active} + {2'b00, c_h_fp};
  assign h_sync_end   = h_sync_start + {2'b00, c_h_sync};
  assign h_total      = h_sync_end + {2'b00, c_h_bp};
  assign v_sync_start = {2'b00, c_v_active} + {2'b00, c_v_fp};
  assign v_sync_end   = v_sync_start + {2'b00, c_v_sync};
  assign v_total      = v_sync_end + {2'b00, c_v_bp};

  assign cfg_bad = (c_h_active == '0) || (c_h_sync == '0) ||
                   (c_v_active == '0) || (c_v_sync == '0) ||
                   (h_total > H_LIMIT) || (v_total > V_LIMIT);

  // Next position. Wrap tests use >= so that a total shrunk below the current count
  // still wraps at the next step instead of running on to the counter limit.
  always_comb begin
    x_inc        = {2'b00, x_q} + HW2'(1);
    y_inc        = {2'b00, y_q} + VW2'(1);
    h_wrap       = (x_inc >= h_total);
    v_wrap       = (y_inc >= v_total);
    nx           = x_inc;
    ny           = {2'b00, y_q};
    enter_origin = 1'b0;
    if (state_q != ST_RUN) begin
      nx           = '0;
      ny           = '0;
      enter_origin = 1'b1;
    end else if (h_wrap) begin
      nx           = '0;
      ny           = v_wrap ? '0 : y_inc;
      enter_origin = v_wrap;
    end
  end

  // Flags of the pixel being entered, so they line up with the registered X/Y.
  always_comb begin
    n_de    = (nx < {2'b00, c_h_active}) && (ny < {2'b00, c_v_active});
    n_hsync = ((nx >= h_sync_start) && (nx < h_sync_end)) ? c_h_pol : ~c_h_pol;
    n_vsync = ((ny >= v_sync_start) && (ny < v_sync_end)) ? c_v_pol : ~c_v_pol;
    n_le    = (nx == (h_total - HW2'(1)));
  end

  // Controller next state: only enabled cycles move it.
  always_comb begin
    state_d = state_q;
    if (bus.Pix_en) begin
      if (cfg_bad) begin
        state_d = ST_HALT;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Raster registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      fs_q    <= 1'b0;
      le_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // pulses last only for the enabled cycle that enters the position
      fs_q <= 1'b0;
      le_q <= 1'b0;
      if (bus.Pix_en) begin
        if (cfg_bad) begin
          err_q   <= 1'b1;
          x_q     <= '0;
          y_q     <= '0;
          de_q    <= 1'b0;
          hsync_q <= ~c_h_pol;
          vsync_q <= ~c_v_pol;
        end else begin
          err_q   <= 1'b0;
          x_q     <= nx[H_WIDTH-1:0];
          y_q     <= ny[V_WIDTH-1:0];
          de_q    <= n_de;
          hsync_q <= n_hsync;
          vsync_q <= n_vsync;
          fs_q    <= enter_origin;
          le_q    <= n_le;
        end
      end
    end
  end

  assign bus.X           = x_q;
  assign bus.Y           = y_q;
  assign bus.De          = de_q;
  assign bus.Hsync       = hsync_q;
  assign bus.Vsync       = vsync_q;
  assign bus.Frame_start = fs_q;
  assign bus.Line_end    = le_q;
  assign bus.Cfg_err     = err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen (hand table, directed corner sequences, random
// stimulus against a position-level reference model).
module tb_vga_timing_gen;
  localparam int HW = 11;
  localparam int VW = 10;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  vga_timing_gen_if #(.H_WIDTH(HW), .V_WIDTH(VW)) bus ();
  vga_timing_gen #(.H_WIDTH(HW), .V_WIDTH(VW)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // {X, Y, De, Hsync, Vsync, Frame_start, Line_end, Cfg_err}
  function automatic logic [31:0] dut_word();
    return 32'({bus.X, bus.Y, bus.De, bus.Hsync, bus.Vsync,
                bus.Frame_start, bus.Line_end, bus.Cfg_err});
  endfunction

  // ---------------- reference model: pixel position plus region rules ----------------
  int m_x = 0, m_y = 0;
  bit m_de, m_hs, m_vs, m_fs, m_le, m_err;
  bit m_pend = 1'b1;
  int s_ha, s_hf, s_hsw, s_hb, s_va, s_vf, s_vsw, s_vb;
  bit s_hp, s_vp;

  task automatic capture();
    s_ha = int'(bus.H_active); s_hf = int'(bus.H_fp);
    s_hsw = int'(bus.H_sync);  s_hb = int'(bus.H_bp);
    s_va = int'(bus.V_active); s_vf = int'(bus.V_fp);
    s_vsw = int'(bus.V_sync);  s_vb = int'(bus.V_bp);
    s_hp = bus.H_pol;          s_vp = bus.V_pol;
  endtask

  function automatic logic [31:0] model_word();
    return 32'({HW'(m_x), VW'(m_y), m_de, m_hs, m_vs, m_fs, m_le, m_err});
  endfunction

  always @(posedge Clk) begin : model_b
    int ha, hf, hsw, hb, va, vf, vsw, vb, ht, vt;
    bit hp, vp, bad;
`ifdef VGA_TIMING_SHADOW_EN
    ha = s_ha; hf = s_hf; hsw = s_hsw; hb = s_hb;
    va = s_va; vf = s_vf; vsw = s_vsw; vb = s_vb;
    hp = s_hp; vp = s_vp;
`else
    ha = int'(bus.H_active); hf = int'(bus.H_fp); hsw = int'(bus.H_sync); hb = int'(bus.H_bp);
    va = int'(bus.V_active); vf = int'(bus.V_fp); vsw = int'(bus.V_sync); vb = int'(bus.V_bp);
    hp = bus.H_pol; vp = bus.V_pol;
`endif
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    bad = (ha == 0) || (hsw == 0) || (va == 0) || (vsw == 0) ||
          (ht > (1 << HW)) || (vt > (1 << VW));
    if (Rst) begin
      m_x = 0; m_y = 0; m_de = 0; m_hs = 0; m_vs = 0; m_fs = 0; m_le = 0; m_err = 0;
      m_pend = 1;
      capture();
    end else if (!bus.Pix_en) begin
      m_fs = 0; m_le = 0;
    end else if (bad) begin
      m_err = 1; m_x = 0; m_y = 0; m_de = 0; m_hs = !hp; m_vs = !vp; m_fs = 0; m_le = 0;
      m_pend = 1;
      capture();
    end else begin
      if (m_pend) begin
        m_x = 0; m_y = 0; m_pend = 0;
      end else if (m_x + 1 >= ht) begin
        m_x = 0;
        m_y = (m_y + 1 >= vt) ? 0 : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
      m_err = 0;
      m_fs  = (m_x == 0) && (m_y == 0);
      m_le  = (m_x == ht - 1);
      m_de  = (m_x < ha) && (m_y < va);
      m_hs  = (m_x >= ha + hf && m_x < ha + hf + hsw) ? hp : !hp;
      m_vs  = (m_y >= va + vf && m_y < va + vf + vsw) ? vp : !vp;
      if (m_fs) capture();
    end
  end

  always @(negedge Clk) begin
    if (chk_on) check("model", dut_word(), model_word());
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_cfg(input int ha, hf, hsw, hb, va, vf, vsw, vb);
    bus.H_active = HW'(ha); bus.H_fp = HW'(hf); bus.H_sync = HW'(hsw); bus.H_bp = HW'(hb);
    bus.V_active = VW'(va); bus.V_fp = VW'(vf); bus.V_sync = VW'(vsw); bus.V_bp = VW'(vb);
  endtask

  task automatic pulse_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic expect_err(input string name, input bit want);
`ifdef VGA_TIMING_SHADOW_EN
    int n = 0;
`endif
    tick();
`ifdef VGA_TIMING_SHADOW_EN
    while (bus.Cfg_err !== want && n < 10000) begin tick(); n++; end
`endif
    check(name, 32'(bus.Cfg_err), 32'(want));
  endtask

  typedef struct { int rst, en, x, y, de, hs, vs, fs, le, err; } vec_t;
  vec_t vec [15];

  initial begin
    int n, cnt_de, cnt_le, cnt_vs, low, first, last, le_at, maxx, gaps, gaps_bad, hold_pulse;
    int exp_len;
    logic [31:0] expw;

    // mode A: H 4/1/2/1 (total 8, sync X5..6), V 2/1/1/1 (total 5, sync Y3), active-low
    vec[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    vec[2]  = '{0, 1, 1, 0, 1, 1, 1, 0, 0, 0};
    vec[3]  = '{0, 0, 1, 0, 1, 1, 1, 0, 0, 0};
    vec[4]  = '{0, 1, 2, 0, 1, 1, 1, 0, 0, 0};
    vec[5]  = '{0, 1, 3, 0, 1, 1, 1, 0, 0, 0};
    vec[6]  = '{0, 1, 4, 0, 0, 1, 1, 0, 0, 0};
    vec[7]  = '{0, 1, 5, 0, 0, 0, 1, 0, 0, 0};
    vec[8]  = '{0, 1, 6, 0, 0, 0, 1, 0, 0, 0};
    vec[9]  = '{0, 1, 7, 0, 0, 1, 1, 0, 1, 0};
    vec[10] = '{0, 0, 7, 0, 0, 1, 1, 0, 0, 0};
    vec[11] = '{0, 1, 0, 1, 1, 1, 1, 0, 0, 0};
    vec[12] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[14] = '{0, 1, 0, 0, 1, 1, 1, 1, 0, 0};

    bus.Pix_en = 1'b1; bus.H_pol = 1'b0; bus.V_pol = 1'b0;
    set_cfg(4, 1, 2, 1, 2, 1, 1, 1);

    // ---- table ----
    for (int i = 0; i < 15; i++) begin
      Rst = (vec[i].rst != 0);
      bus.Pix_en = (vec[i].en != 0);
      tick();
      expw = 32'({HW'(vec[i].x), VW'(vec[i].y), 1'(vec[i].de), 1'(vec[i].hs), 1'(vec[i].vs),
                  1'(vec[i].fs), 1'(vec[i].le), 1'(vec[i].err)});
      check($sformatf("table%0d", i), dut_word(), expw);
      chk_on = 1'b1;
    end
    Rst = 1'b0;

    // ---- random enable / occasional reset on mode A ----
    for (int i = 0; i < 400; i++) begin
      bus.Pix_en = ($urandom_range(0, 3) != 0);
      Rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    Rst = 1'b0;

    // ---- Pix_en alternating: line takes 16 clocks, no pulses on hold cycles ----
    bus.Pix_en = 1'b1;
    pulse_reset();
    last = -1; gaps = 0; gaps_bad = 0; hold_pulse = 0;
    for (int i = 0; i < 200; i++) begin
      bus.Pix_en = (i % 2 == 0);
      tick();
      if (!bus.Pix_en && (bus.Frame_start || bus.Line_end)) hold_pulse++;
      if (bus.Line_end) begin
        if (last >= 0) begin
          gaps++;
          if (i - last != 16) gaps_bad++;
        end
        last = i;
      end
    end
    check("alt_gap_bad", 32'(gaps_bad), 32'd0);
    check("alt_gaps_seen", 32'(gaps >= 10), 32'd1);
    check("alt_hold_pulse", 32'(hold_pulse), 32'd0);

    // ---- 640x480 line: 800 clocks, Hsync low X 656..751, 640 De ----
    set_cfg(640, 16, 96, 48, 480, 10, 2, 33);
    bus.Pix_en = 1'b1;
    pulse_reset();
    tick();
    check("vga_first", dut_word(), 32'h3C);
    low = 0; first = -1; last = -1; cnt_de = 0; le_at = -1;
    for (int i = 0; i < 800; i++) begin
      if (!bus.Hsync) begin
        low++;
        if (first < 0) first = int'(bus.X);
        last = int'(bus.X);
      end
      cnt_de += int'(bus.De);
      if (bus.Line_end) le_at = i;
      tick();
    end
    check("vga_hs_low", 32'(low), 32'd96);
    check("vga_hs_first", 32'(first), 32'd656);
    check("vga_hs_last", 32'(last), 32'd751);
    check("vga_de_line", 32'(cnt_de), 32'd640);
    check("vga_le_at", 32'(le_at), 32'd799);
    check("vga_next_line", 32'({bus.X, bus.Y}), 32'({HW'(0), VW'(1)}));

    // ---- small full frame: H 8/2/3/2 (15), V 6/1/2/1 (10) -> 150 clocks ----
    set_cfg(8, 2, 3, 2, 6, 1, 2, 1);
    pulse_reset();
    tick();
    n = 0; cnt_de = 0; cnt_le = 0; cnt_vs = 0;
    do begin
      cnt_de += int'(bus.De);
      cnt_le += int'(bus.Line_end);
      cnt_vs += int'(!bus.Vsync);
      n++;
      tick();
    end while (!bus.Frame_start && n < 1000);
    check("frame_period", 32'(n), 32'd150);
    check("frame_de", 32'(cnt_de), 32'd48);
    check("frame_le", 32'(cnt_le), 32'd10);
    check("frame_vs_low", 32'(cnt_vs), 32'd30);

    // ---- Rst mid-frame at (5,3) ----
    n = 0;
    while (!(bus.X == HW'(5) && bus.Y == VW'(3)) && n < 400) begin tick(); n++; end
    check("rst_reach", 32'({bus.X, bus.Y}), 32'({HW'(5), VW'(3)}));
    Rst = 1'b1;
    tick();
    check("rst_vals", dut_word(), 32'h0);
    Rst = 1'b0;
    tick();
    check("rst_restart", dut_word(), 32'h3C);

    // ---- invalid H_sync mid-run, then restore ----
    set_cfg(4, 1, 2, 1, 2, 1, 1, 1);
    pulse_reset();
    repeat (20) tick();
    bus.H_sync = '0;
    tick();
`ifdef VGA_TIMING_SHADOW_EN
    n = 0;
    while (!bus.Cfg_err && n < 100) begin tick(); n++; end
`endif
    check("herr_word", dut_word(), 32'h19);
    tick();
    check("herr_hold", dut_word(), 32'h19);
    bus.H_sync = HW'(2);
    tick();
`ifdef VGA_TIMING_SHADOW_EN
    n = 0;
    while (!bus.Frame_start && n < 100) begin tick(); n++; end
`endif
    check("herr_recover", dut_word(), 32'h3C);

    // ---- total limits: 2^W is legal, 2^W+1 is not ----
    set_cfg(4, 1, 2, 1, 1020, 1, 1, 3);
    expect_err("v_over", 1'b1);
    bus.V_bp = VW'(2);
    expect_err("v_exact", 1'b0);
    set_cfg(1944, 1, 2, 102, 1020, 1, 1, 2);
    expect_err("h_over", 1'b1);
    bus.H_bp = HW'(101);
    expect_err("h_exact", 1'b0);

    // ---- H_active shrinks mid-frame: H 16/2/4/2 (24) -> 8 (16), V 4/1/1/1 ----
    set_cfg(16, 2, 4, 2, 4, 1, 1, 1);
    pulse_reset();
    n = 0;
    while (bus.Y != VW'(2) && n < 200) begin tick(); n++; end
    check("shrink_reach", 32'({bus.X, bus.Y}), 32'({HW'(0), VW'(2)}));
    bus.H_active = HW'(8);
    n = 0;
    while (!bus.Line_end && n < 100) begin tick(); n++; end
    check("shrink_le_seen", 32'(bus.Line_end), 32'd1);
    n = 0;
    do begin tick(); n++; end while (!bus.Line_end && n < 100);
`ifdef VGA_TIMING_SHADOW_EN
    exp_len = 24;
`else
    exp_len = 16;
`endif
    check("shrink_line_len", 32'(n), 32'(exp_len));
    maxx = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (int'(bus.X) > maxx) maxx = int'(bus.X);
    end
    check("shrink_max_x", 32'(maxx), 32'(exp_len - 1));

    // ---- total shrinks below the current X: must wrap, not run on ----
    set_cfg(16, 2, 4, 2, 4, 1, 1, 1);
    pulse_reset();
    n = 0;
    while (bus.X != HW'(20) && n < 100) begin tick(); n++; end
    check("overshoot_reach", 32'(bus.X), 32'd20);
    bus.H_active = HW'(2);
    tick();
`ifdef VGA_TIMING_SHADOW_EN
    check("overshoot_wrap", 32'(bus.X), 32'd21);
`else
    check("overshoot_wrap", 32'(bus.X), 32'd0);
`endif

    // ---- random configurations with mid-run changes ----
    for (int c = 0; c < 8; c++) begin
      set_cfg($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 4),
              $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 2),
              $urandom_range(0, 3), $urandom_range(0, 2));
      bus.H_pol = 1'($urandom_range(0, 1));
      bus.V_pol = 1'($urandom_range(0, 1));
      for (int i = 0; i < 250; i++) begin
        bus.Pix_en = ($urandom_range(0, 3) != 0);
        Rst = ($urandom_range(0, 299) == 0);
        if (i == 120) bus.H_active = HW'($urandom_range(1, 12));
        if (i == 180) bus.V_sync = VW'($urandom_range(1, 3));
        tick();
      end
      Rst = 1'b0;
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
